// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the MEM-side handshake, the register-file write port
// and the forwarding outputs of the write-back stage.
interface wb_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RAW  = 5
);
   localparam int unsigned AW = $clog2(XLEN / 8);

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] pc_add4;
   logic [XLEN-1:0] comp_ex_result;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] mem_data;
   logic [1:0]      rw_sel;
   logic [RAW-1:0]  rd_addr;
   logic            rd_we;
   logic [1:0]      ld_size;
   logic            ld_unsigned;
   logic [AW-1:0]   ld_addr_lo;
   logic            rf_gnt;
   logic            rf_we;
   logic [RAW-1:0]  rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            fwd_valid;
   logic [RAW-1:0]  fwd_addr;
   logic [XLEN-1:0] fwd_data;

   // Producer side (MEM stage, register file arbiter, consumers of bypass)
   modport master (
      output in_valid, pc_add4, comp_ex_result, alu_result, mem_data,
             rw_sel, rd_addr, rd_we, ld_size, ld_unsigned, ld_addr_lo, rf_gnt,
      input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data
   );

   // Write-back stage side
   modport slave (
      input  in_valid, pc_add4, comp_ex_result, alu_result, mem_data,
             rw_sel, rd_addr, rd_we, ld_size, ld_unsigned, ld_addr_lo, rf_gnt,
      output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data
   );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: buffered write-back stage. Selects the result source, optionally
// aligns/extends load data (macro WB_LOAD_EXT_EN), holds results in a
// 2-entry FIFO and drives the register-file write port under rf_gnt.
// The head entry is exposed for forwarding; retirements are counted.
module wb_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RAW  = 5,
   parameter int unsigned CNTW = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_stage_if.slave       bus,
   output logic [CNTW-1:0] retire_cnt
);
   localparam int unsigned AW = $clog2(XLEN / 8);

   localparam logic [1:0] REGWD_PC      = 2'd0;
   localparam logic [1:0] REGWD_COMPOUT = 2'd1;
   localparam logic [1:0] REGWD_ALUOUT  = 2'd2;

   typedef struct packed {
      logic            wflag;
      logic [RAW-1:0]  addr;
      logic [XLEN-1:0] data;
   } wb_entry_t;

   logic [XLEN-1:0] ld_data_c;
   logic [XLEN-1:0] result_c;
   wb_entry_t       in_entry_c;
   logic            push_c;
   logic            pop_c;

   wb_entry_t       head_q, head_d;
   wb_entry_t       tail_q, tail_d;
   logic [1:0]      count_q, count_d;
   logic            in_ready_q, in_ready_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

`ifdef WB_LOAD_EXT_EN
   logic [AW-1:0]   ld_idx_c;
   logic [XLEN-1:0] ld_shift_c;

   // Align load data to its byte offset, then mask and extend to XLEN
   always_comb begin
      ld_idx_c   = bus.ld_addr_lo;
      ld_data_c  = '0;
      case (bus.ld_size)
         2'b00:   ld_idx_c = bus.ld_addr_lo;
         2'b01:   ld_idx_c = bus.ld_addr_lo & ~AW'(1);
         default: ld_idx_c = (XLEN == 64 && bus.ld_size == 2'b11) ? '0
                                                                 : (bus.ld_addr_lo & ~AW'(3));
      endcase
      ld_shift_c = bus.mem_data >> {ld_idx_c, 3'b000};
      case (bus.ld_size)
         2'b00: ld_data_c = bus.ld_unsigned ? XLEN'(ld_shift_c[7:0])
                                            : XLEN'($signed(ld_shift_c[7:0]));
         2'b01: ld_data_c = bus.ld_unsigned ? XLEN'(ld_shift_c[15:0])
                                            : XLEN'($signed(ld_shift_c[15:0]));
         2'b10: ld_data_c = bus.ld_unsigned ? XLEN'(ld_shift_c[31:0])
                                            : XLEN'($signed(ld_shift_c[31:0]));
         default: begin
            // dword on RV64; on RV32 the illegal dword code behaves as word
            if (XLEN == 64) ld_data_c = ld_shift_c;
            else            ld_data_c = bus.ld_unsigned ? XLEN'(ld_shift_c[31:0])
                                                        : XLEN'($signed(ld_shift_c[31:0]));
         end
      endcase
   end
`else
   logic unused_ld_ctrl;

   // Memory unit already extended the load; pass it through untouched
   assign ld_data_c      = bus.mem_data;
   assign unused_ld_ctrl = ^{bus.ld_size, bus.ld_unsigned, bus.ld_addr_lo};
`endif

   // Result source select and entry formation; x0 writes are stripped here
   always_comb begin
      result_c = ld_data_c;
      case (bus.rw_sel)
         REGWD_PC:      result_c = bus.pc_add4;
         REGWD_COMPOUT: result_c = bus.comp_ex_result;
         REGWD_ALUOUT:  result_c = bus.alu_result;
         default:       result_c = ld_data_c;
      endcase
      in_entry_c.wflag = bus.rd_we && (bus.rd_addr != '0);
      in_entry_c.addr  = bus.rd_addr;
      in_entry_c.data  = result_c;
   end

   assign push_c = bus.in_valid && in_ready_q;
   assign pop_c  = (count_q != 2'd0) && (bus.rf_gnt || !head_q.wflag);

   // FIFO next state; an empty head is zeroed so the outputs read 0
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_c, pop_c})
         2'b10: begin
            if (count_q == 2'd0) head_d = in_entry_c;
            else                 tail_d = in_entry_c;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = (count_q == 2'd2) ? tail_q : '0;
            tail_d  = '0;
            count_d = count_q - 2'd1;
         end
         // push with pop only happens at count 1: the new entry becomes head
         2'b11: head_d = in_entry_c;
         default: ;
      endcase
      in_ready_d = (count_d < 2'd2);
      cnt_d      = cnt_q + CNTW'(pop_c);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.rf_we     = head_q.wflag;
   assign bus.rf_waddr  = head_q.addr;
   assign bus.rf_wdata  = head_q.data;
   assign bus.fwd_valid = head_q.wflag;
   assign bus.fwd_addr  = head_q.addr;
   assign bus.fwd_data  = head_q.data;
   assign retire_cnt    = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with a scoreboard of expected register-file
// writes; a negedge monitor pops and compares every granted write.
module tb_wb_stage;
   localparam logic [1:0] RS_PC   = 2'd0;
   localparam logic [1:0] RS_COMP = 2'd1;
   localparam logic [1:0] RS_ALU  = 2'd2;
   localparam logic [1:0] RS_LOAD = 2'd3;
`ifdef WB_LOAD_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] retire_cnt;
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         exp_ret = 0;
   exp_t       exp_q[$];
   logic       pend_w;
   exp_t       pend_e;

   wb_stage_if #(.XLEN(32), .RAW(5)) bus ();

   wb_stage #(.XLEN(32), .RAW(5), .CNTW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every granted write must match the oldest expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && bus.rf_we && bus.rf_gnt) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write",
                     bus.rf_waddr, bus.rf_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr",   64'(bus.rf_waddr),  64'(e.a));
            check("wr_data",   64'(bus.rf_wdata),  64'(e.d));
            check("fwd_valid", 64'(bus.fwd_valid), 64'(1));
            check("fwd_addr",  64'(bus.fwd_addr),  64'(e.a));
            check("fwd_data",  64'(bus.fwd_data),  64'(e.d));
         end
      end
   end

   task automatic set_fields(input logic [1:0] rw, input logic [31:0] val, input logic [4:0] rd,
                             input logic we, input logic [1:0] sz, input logic uns,
                             input logic [1:0] lo, input logic [31:0] exp_d);
      bus.rw_sel         = rw;
      bus.pc_add4        = (rw == RS_PC)   ? val : 32'h1111_1111;
      bus.comp_ex_result = (rw == RS_COMP) ? val : 32'h2222_2222;
      bus.alu_result     = (rw == RS_ALU)  ? val : 32'h3333_3333;
      bus.mem_data       = (rw == RS_LOAD) ? val : 32'h4444_4444;
      bus.rd_addr        = rd;
      bus.rd_we          = we;
      bus.ld_size        = sz;
      bus.ld_unsigned    = uns;
      bus.ld_addr_lo     = lo;
      bus.in_valid       = 1'b1;
      pend_w             = we && (rd != 5'd0);
      pend_e.a           = rd;
      pend_e.d           = exp_d;
   endtask

   // Hold in_valid until the stage accepts; expectation is queued at acceptance
   task automatic wait_accept();
      bit acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = bus.in_ready;
         if (acc) begin
            if (pend_w) exp_q.push_back(pend_e);
            exp_ret++;
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: in_ready %0b, expected 1 within 50 cycles", bus.in_ready);
      end
   endtask

   task automatic send(input logic [1:0] rw, input logic [31:0] val, input logic [4:0] rd,
                       input logic we, input logic [1:0] sz, input logic uns,
                       input logic [1:0] lo, input logic [31:0] exp_d);
      set_fields(rw, val, rd, we, sz, uns, lo, exp_d);
      wait_accept();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   c0;
      logic stale;
      rst_n = 1'b0;
      bus.rf_gnt = 1'b0;
      set_fields(RS_PC, 32'h0, 5'd0, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(bus.in_ready),  64'(1));
      check("rst_rf_we",     64'(bus.rf_we),     64'(0));
      check("rst_waddr",     64'(bus.rf_waddr),  64'(0));
      check("rst_wdata",     64'(bus.rf_wdata),  64'(0));
      check("rst_fwd_valid", 64'(bus.fwd_valid), 64'(0));
      check("rst_retire",    64'(retire_cnt),    64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU source, granted write the cycle after acceptance
      bus.rf_gnt = 1'b1;
      send(RS_ALU, 32'h1234_5678, 5'd5, 1'b1, 2'b10, 1'b0, 2'd0, 32'h1234_5678);
      idle();
      check("alu_rf_we", 64'(bus.rf_we),    64'(1));
      check("alu_waddr", 64'(bus.rf_waddr), 64'(5));
      check("alu_wdata", 64'(bus.rf_wdata), 64'(32'h1234_5678));
      @(posedge clk);
      #1;
      check("alu_retire",   64'(retire_cnt), 64'(1));
      check("alu_rf_we_lo", 64'(bus.rf_we),  64'(0));

      // Remaining sources back to back at one per cycle
      c0 = cyc;
      send(RS_PC,   32'h0000_1004, 5'd6, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0000_1004);
      send(RS_COMP, 32'h0000_0001, 5'd7, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0000_0001);
      send(RS_ALU,  32'hCAFE_F00D, 5'd8, 1'b1, 2'b10, 1'b0, 2'd0, 32'hCAFE_F00D);
      idle();
      check("throughput_cycles", 64'(cyc - c0), 64'(3));
      repeat (2) @(posedge clk);
      #1;
      check("src_retire", 64'(retire_cnt), 64'(4));

      // x0 and rd_we=0 entries retire without a grant and never write
      bus.rf_gnt = 1'b0;
      send(RS_ALU, 32'h0000_0055, 5'd0, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0);
      send(RS_ALU, 32'h0000_0066, 5'd9, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0);
      idle();
      check("nowr_rf_we", 64'(bus.rf_we), 64'(0));
      @(posedge clk);
      #1;
      check("nowr_retire",   64'(retire_cnt),   64'(6));
      check("nowr_in_ready", 64'(bus.in_ready), 64'(1));

      // Load alignment and extension
      bus.rf_gnt = 1'b1;
      send(RS_LOAD, 32'h80FF_7F01, 5'd10, 1'b1, 2'b00, 1'b0, 2'd2, EXT ? 32'hFFFF_FFFF : 32'h80FF_7F01);
      send(RS_LOAD, 32'h80FF_7F01, 5'd11, 1'b1, 2'b00, 1'b0, 2'd3, EXT ? 32'hFFFF_FF80 : 32'h80FF_7F01);
      send(RS_LOAD, 32'h80FF_7F01, 5'd12, 1'b1, 2'b01, 1'b1, 2'd2, EXT ? 32'h0000_80FF : 32'h80FF_7F01);
      send(RS_LOAD, 32'h80FF_7F01, 5'd13, 1'b1, 2'b01, 1'b0, 2'd1, EXT ? 32'h0000_7F01 : 32'h80FF_7F01);
      send(RS_LOAD, 32'h80FF_7F01, 5'd14, 1'b1, 2'b00, 1'b1, 2'd1, EXT ? 32'h0000_007F : 32'h80FF_7F01);
      send(RS_LOAD, 32'h80FF_7F01, 5'd15, 1'b1, 2'b10, 1'b0, 2'd3, 32'h80FF_7F01);
      send(RS_LOAD, 32'h80FF_7F01, 5'd16, 1'b1, 2'b11, 1'b0, 2'd2, 32'h80FF_7F01);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("load_retire", 64'(retire_cnt), 64'(13));

      // Backpressure: two accepted, third stalls until the first pop
      bus.rf_gnt = 1'b0;
      send(RS_ALU, 32'hA0A0_A0A0, 5'd17, 1'b1, 2'b10, 1'b0, 2'd0, 32'hA0A0_A0A0);
      send(RS_ALU, 32'hB0B0_B0B0, 5'd18, 1'b1, 2'b10, 1'b0, 2'd0, 32'hB0B0_B0B0);
      set_fields(RS_ALU, 32'hC0C0_C0C0, 5'd19, 1'b1, 2'b10, 1'b0, 2'd0, 32'hC0C0_C0C0);
      check("bp_in_ready_full", 64'(bus.in_ready), 64'(0));
      check("bp_head_addr0",    64'(bus.rf_waddr), 64'(17));
      repeat (2) @(posedge clk);
      #1;
      check("bp_in_ready_hold", 64'(bus.in_ready), 64'(0));
      check("bp_head_addr1",    64'(bus.rf_waddr), 64'(17));
      check("bp_head_data1",    64'(bus.rf_wdata), 64'(32'hA0A0_A0A0));
      check("bp_rf_we",         64'(bus.rf_we),    64'(1));
      bus.rf_gnt = 1'b1;
      c0 = cyc;
      wait_accept();
      idle();
      check("bp_third_accept_cycle", 64'(cyc - c0), 64'(2));
      repeat (2) @(posedge clk);
      #1;
      check("bp_retire", 64'(retire_cnt), 64'(0));

      // Asynchronous reset with two buffered entries
      bus.rf_gnt = 1'b0;
      send(RS_ALU, 32'hD0D0_D0D0, 5'd20, 1'b1, 2'b10, 1'b0, 2'd0, 32'hD0D0_D0D0);
      send(RS_ALU, 32'hE0E0_E0E0, 5'd21, 1'b1, 2'b10, 1'b0, 2'd0, 32'hE0E0_E0E0);
      idle();
      check("pre_rst_in_ready", 64'(bus.in_ready), 64'(0));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rf_we",     64'(bus.rf_we),     64'(0));
      check("arst_waddr",     64'(bus.rf_waddr),  64'(0));
      check("arst_wdata",     64'(bus.rf_wdata),  64'(0));
      check("arst_fwd_data",  64'(bus.fwd_data),  64'(0));
      check("arst_in_ready",  64'(bus.in_ready),  64'(1));
      check("arst_retire",    64'(retire_cnt),    64'(0));
      exp_q.delete();
      exp_ret = 0;
      #2;
      rst_n = 1'b1;
      bus.rf_gnt = 1'b1;
      stale = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.rf_we) stale = 1'b1;
      end
      check("arst_no_stale_write", 64'(stale), 64'(0));

      // Counter wrap: 17 retirements on a 4-bit counter
      for (int i = 0; i < 17; i++)
         send(RS_PC, 32'(i), 5'd0, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("wrap_retire", 64'(retire_cnt), 64'(1));

      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
